axis_rate_meter: RTL and testbench

AXIS_RATE_METER -- requirements
Module: axis_rate_meter

---
 rtl/axis_rate_meter.sv | 209 ++++++++++++++++++++
 tb/tb_axis_rate_meter.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_rate_meter.sv
// rtl/axis_rate_meter.sv - passive AXI-Stream throughput / stall / idle window meter
//
// Ports:
//   clk, rst_n            : clock, asynchronous active-low reset
//   mon_axis_tkeep/tvalid/
//   tready/tlast          : observed stream (inputs only, never driven)
//   enable                : measurement enable
//   window_len            : window length in clk cycles (0 = stop after current window)
//   stat_bytes/frames/
//   stall/idle            : totals of the last closed window (registered)
//   stat_valid            : one-cycle pulse when the stat_* outputs update
//   stat_saturated        : some accumulator clamped in the last closed window
module axis_rate_meter #(
    parameter int KEEP_ENABLE = 1,
    parameter int KEEP_WIDTH  = 8,
    parameter int CNT_WIDTH   = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [KEEP_WIDTH-1:0] mon_axis_tkeep,
    input  logic                  mon_axis_tvalid,
    input  logic                  mon_axis_tready,
    input  logic                  mon_axis_tlast,
    input  logic                  enable,
    input  logic [CNT_WIDTH-1:0]  window_len,
    output logic [CNT_WIDTH-1:0]  stat_bytes,
    output logic [CNT_WIDTH-1:0]  stat_frames,
    output logic [CNT_WIDTH-1:0]  stat_stall,
    output logic [CNT_WIDTH-1:0]  stat_idle,
    output logic                  stat_valid,
    output logic                  stat_saturated
);

    localparam int                   PW      = $clog2(KEEP_WIDTH + 1);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

    typedef enum logic {
        S_IDLE    = 1'b0,
        S_MEASURE = 1'b1
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [CNT_WIDTH-1:0] r_len;
    logic [CNT_WIDTH-1:0] r_cnt;
    logic [CNT_WIDTH-1:0] r_acc_bytes;
    logic [CNT_WIDTH-1:0] r_acc_frames;
    logic [CNT_WIDTH-1:0] r_acc_stall;
    logic [CNT_WIDTH-1:0] r_acc_idle;
    logic                 r_acc_sat;

    // Cycle classification: exactly one of beat / stall / idle is true
    logic w_beat;
    logic w_stall;
    logic w_idle;
    logic w_frame;

    assign w_beat  = mon_axis_tvalid & mon_axis_tready;
    assign w_stall = mon_axis_tvalid & ~mon_axis_tready;
    assign w_idle  = ~mon_axis_tvalid;
    assign w_frame = w_beat & mon_axis_tlast;

    // Bytes carried by this cycle's beat (0 when no beat)
    logic [PW-1:0] w_beat_bytes;

    always_comb begin
        w_beat_bytes = '0;
        if (KEEP_ENABLE != 0) begin
            for (int i = 0; i < KEEP_WIDTH; i++) begin
                w_beat_bytes = w_beat_bytes + PW'(mon_axis_tkeep[i]);
            end
        end else begin
            w_beat_bytes = PW'(KEEP_WIDTH);
        end
        if (!w_beat) begin
            w_beat_bytes = '0;
        end
    end

    // Byte sum carries one extra bit so an overflow is seen before clamping
    logic [CNT_WIDTH:0]   w_bytes_sum;
    logic [CNT_WIDTH-1:0] w_bytes_nxt;
    logic                 w_bytes_ovf;

    assign w_bytes_sum = {1'b0, r_acc_bytes} + (CNT_WIDTH + 1)'(w_beat_bytes);
    assign w_bytes_ovf = w_bytes_sum[CNT_WIDTH];
    assign w_bytes_nxt = w_bytes_ovf ? CNT_MAX : w_bytes_sum[CNT_WIDTH-1:0];

    // Single-step counters clamp at all-ones
    logic [CNT_WIDTH-1:0] w_frames_nxt;
    logic [CNT_WIDTH-1:0] w_stall_nxt;
    logic [CNT_WIDTH-1:0] w_idle_nxt;
    logic                 w_frames_ovf;
    logic                 w_stall_ovf;
    logic                 w_idle_ovf;

    assign w_frames_ovf = w_frame & (r_acc_frames == CNT_MAX);
    assign w_stall_ovf  = w_stall & (r_acc_stall == CNT_MAX);
    assign w_idle_ovf   = w_idle & (r_acc_idle == CNT_MAX);

    assign w_frames_nxt = (w_frame && !w_frames_ovf) ? r_acc_frames + CNT_ONE : r_acc_frames;
    assign w_stall_nxt  = (w_stall && !w_stall_ovf)  ? r_acc_stall + CNT_ONE  : r_acc_stall;
    assign w_idle_nxt   = (w_idle && !w_idle_ovf)    ? r_acc_idle + CNT_ONE   : r_acc_idle;

    logic w_sat_nxt;
    assign w_sat_nxt = r_acc_sat | w_bytes_ovf | w_frames_ovf | w_stall_ovf | w_idle_ovf;

    // r_len is never 0 while measuring, so len-1 cannot underflow there
    logic w_close;
    assign w_close = (r_cnt == (r_len - CNT_ONE));

    // Control decoded by the FSM
    logic w_start;
    logic w_count;
    logic w_publish;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        w_count     = 1'b0;
        w_publish   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (enable && (window_len != '0)) begin
                    w_state_nxt = S_MEASURE;
                    w_start     = 1'b1;
                end
            end
            S_MEASURE: begin
                // Dropping enable wins over a coincident close: window discarded
                if (!enable) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_count = 1'b1;
                    if (w_close) begin
                        w_publish = 1'b1;
                        if (window_len == '0) begin
                            w_state_nxt = S_IDLE;
                        end
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Accumulators, cycle counter and latched window length
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_len        <= '0;
            r_cnt        <= '0;
            r_acc_bytes  <= '0;
            r_acc_frames <= '0;
            r_acc_stall  <= '0;
            r_acc_idle   <= '0;
            r_acc_sat    <= 1'b0;
        end else if (w_start || w_publish) begin
            // Re-latch at close keeps consecutive windows gapless
            r_len        <= window_len;
            r_cnt        <= '0;
            r_acc_bytes  <= '0;
            r_acc_frames <= '0;
            r_acc_stall  <= '0;
            r_acc_idle   <= '0;
            r_acc_sat    <= 1'b0;
        end else if (w_count) begin
            r_cnt        <= r_cnt + CNT_ONE;
            r_acc_bytes  <= w_bytes_nxt;
            r_acc_frames <= w_frames_nxt;
            r_acc_stall  <= w_stall_nxt;
            r_acc_idle   <= w_idle_nxt;
            r_acc_sat    <= w_sat_nxt;
        end
    end

    // Published statistics include the closing cycle's own contribution
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_bytes     <= '0;
            stat_frames    <= '0;
            stat_stall     <= '0;
            stat_idle      <= '0;
            stat_valid     <= 1'b0;
            stat_saturated <= 1'b0;
        end else begin
            stat_valid <= w_publish;
            if (w_publish) begin
                stat_bytes     <= w_bytes_nxt;
                stat_frames    <= w_frames_nxt;
                stat_stall     <= w_stall_nxt;
                stat_idle      <= w_idle_nxt;
                stat_saturated <= w_sat_nxt;
            end
        end
    end

endmodule

// File: tb/tb_axis_rate_meter.sv
// tb/tb_axis_rate_meter.sv - self-checking bench for axis_rate_meter
module tb_axis_rate_meter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  tkeep;
    logic        tvalid;
    logic        tready;
    logic        tlast;
    logic        enable;
    logic [31:0] wl;

    logic [31:0] a_bytes, a_frames, a_stall, a_idle;
    logic        a_valid, a_sat;
    logic [7:0]  b_bytes, b_frames, b_stall, b_idle;
    logic        b_valid, b_sat;

    int total  = 0;
    int passed = 0;
    int pulses = 0;

    always #5 clk = ~clk;

    axis_rate_meter #(.KEEP_ENABLE(1), .KEEP_WIDTH(8), .CNT_WIDTH(32)) dut_a (
        .clk(clk), .rst_n(rst_n), .mon_axis_tkeep(tkeep), .mon_axis_tvalid(tvalid),
        .mon_axis_tready(tready), .mon_axis_tlast(tlast), .enable(enable), .window_len(wl),
        .stat_bytes(a_bytes), .stat_frames(a_frames), .stat_stall(a_stall), .stat_idle(a_idle),
        .stat_valid(a_valid), .stat_saturated(a_sat)
    );

    axis_rate_meter #(.KEEP_ENABLE(1), .KEEP_WIDTH(8), .CNT_WIDTH(8)) dut_b (
        .clk(clk), .rst_n(rst_n), .mon_axis_tkeep(tkeep), .mon_axis_tvalid(tvalid),
        .mon_axis_tready(tready), .mon_axis_tlast(tlast), .enable(enable), .window_len(wl[7:0]),
        .stat_bytes(b_bytes), .stat_frames(b_frames), .stat_stall(b_stall), .stat_idle(b_idle),
        .stat_valid(b_valid), .stat_saturated(b_sat)
    );

    // Window model: unbounded integer sums, clamped only when published
    typedef struct packed {
        bit     meas;
        longint len;
        longint n;
        longint b;
        longint f;
        longint s;
        longint i;
        longint ob;
        longint of;
        longint os;
        longint oi;
        bit     ov;
        bit     osat;
    } mdl_t;

    mdl_t ma = '0;
    mdl_t mb = '0;

    function automatic longint clampv(longint v, longint maxv);
        return (v > maxv) ? maxv : v;
    endfunction

    function automatic mdl_t mstep(mdl_t m, longint maxv, bit en, longint wlen,
                                   bit v, bit r, bit l, longint nbytes);
        mdl_t x = m;
        x.ov = 1'b0;
        if (x.meas) begin
            if (!en) begin
                x.meas = 1'b0;
            end else begin
                if (v && r) begin
                    x.b += nbytes;
                    if (l) x.f++;
                end else if (v) begin
                    x.s++;
                end else begin
                    x.i++;
                end
                x.n++;
                if (x.n == x.len) begin
                    x.ob   = clampv(x.b, maxv);
                    x.of   = clampv(x.f, maxv);
                    x.os   = clampv(x.s, maxv);
                    x.oi   = clampv(x.i, maxv);
                    x.osat = (x.b > maxv) || (x.f > maxv) || (x.s > maxv) || (x.i > maxv);
                    x.ov   = 1'b1;
                    x.n = 0; x.b = 0; x.f = 0; x.s = 0; x.i = 0;
                    x.len = wlen;
                    if (wlen == 0) x.meas = 1'b0;
                end
            end
        end else if (en && wlen != 0) begin
            x.meas = 1'b1;
            x.len  = wlen;
            x.n = 0; x.b = 0; x.f = 0; x.s = 0; x.i = 0;
        end
        return x;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ma = '0;
            mb = '0;
        end else begin
            ma = mstep(ma, 64'd4294967295, enable, longint'(wl), tvalid, tready, tlast,
                       longint'($countones(tkeep)));
            mb = mstep(mb, 64'd255, enable, longint'(wl[7:0]), tvalid, tready, tlast,
                       longint'($countones(tkeep)));
        end
    end

    task automatic chk(input string name, input longint act, input longint exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    task automatic cmp_inst(input string nm, input longint b, input longint f, input longint s,
                            input longint i, input bit v, input bit sat, input mdl_t m);
        total++;
        if (b == m.ob && f == m.of && s == m.os && i == m.oi && v == m.ov && sat == m.osat) begin
            passed++;
        end else begin
            $display("FAIL %s t=%0t got b=%0d f=%0d s=%0d i=%0d v=%0d sat=%0d expected b=%0d f=%0d s=%0d i=%0d v=%0d sat=%0d",
                     nm, $time, b, f, s, i, v, sat, m.ob, m.of, m.os, m.oi, m.ov, m.osat);
        end
    endtask

    always @(negedge clk) begin
        cmp_inst("model_a", longint'(a_bytes), longint'(a_frames), longint'(a_stall),
                 longint'(a_idle), a_valid, a_sat, ma);
        cmp_inst("model_b", longint'(b_bytes), longint'(b_frames), longint'(b_stall),
                 longint'(b_idle), b_valid, b_sat, mb);
        if (a_valid) pulses++;
    end

    task automatic step(input bit v, input bit r, input bit l, input logic [7:0] k);
        tvalid = v;
        tready = r;
        tlast  = l;
        tkeep  = k;
        @(posedge clk);
        #2;
    endtask

    initial begin
        int  p0;
        bit  found;
        rst_n  = 1'b0;
        enable = 1'b0;
        wl     = '0;
        tvalid = 1'b0;
        tready = 1'b0;
        tlast  = 1'b0;
        tkeep  = '0;
        repeat (3) @(posedge clk);
        #2;
        chk("reset_bytes", longint'(a_bytes), 0);
        chk("reset_valid", longint'(a_valid), 0);
        rst_n = 1'b1;
        step(0, 0, 0, 8'h00);
        step(0, 0, 0, 8'h00);

        // Full rate, tlast every 10th beat, two 100-cycle windows
        wl = 100;
        enable = 1'b1;
        p0 = pulses;
        for (int g = 0; g < 205; g++) step(1, 1, (g % 10) == 9, 8'hFF);
        chk("full_pulses", longint'(pulses - p0), 2);
        chk("full_bytes", longint'(a_bytes), 800);
        chk("full_frames", longint'(a_frames), 10);
        chk("full_stall", longint'(a_stall), 0);
        chk("full_idle", longint'(a_idle), 0);
        chk("full_b_bytes", longint'(b_bytes), 255);
        chk("full_b_sat", longint'(b_sat), 1);
        enable = 1'b0;
        step(0, 0, 0, 8'h00);
        step(0, 0, 0, 8'h00);

        // Saturation then an idle window clears it
        wl = 100;
        enable = 1'b1;
        step(1, 1, 0, 8'hFF);
        found = 1'b0;
        for (int c = 0; c < 300 && !found; c++) begin
            step(1, 1, 0, 8'hFF);
            if (b_valid) found = 1'b1;
        end
        chk("sat_pub_seen", longint'(found), 1);
        chk("sat_b_bytes", longint'(b_bytes), 255);
        chk("sat_b_flag", longint'(b_sat), 1);
        found = 1'b0;
        for (int c = 0; c < 300 && !found; c++) begin
            step(0, 0, 0, 8'h00);
            if (b_valid) found = 1'b1;
        end
        chk("idle_pub_seen", longint'(found), 1);
        chk("idle_b_bytes", longint'(b_bytes), 0);
        chk("idle_b_flag", longint'(b_sat), 0);
        chk("idle_b_idle", longint'(b_idle), 100);
        enable = 1'b0;
        step(0, 0, 0, 8'h00);
        step(0, 0, 0, 8'h00);

        // Partial keep, stalls and idles in a 20-cycle window
        wl = 20;
        enable = 1'b1;
        step(0, 0, 0, 8'h00);
        for (int c = 0; c < 10; c++) step(1, 1, c == 9, 8'h0F);
        for (int c = 0; c < 5; c++) step(1, 0, 0, 8'hFF);
        for (int c = 0; c < 5; c++) step(0, 0, 0, 8'h00);
        chk("mix_valid", longint'(a_valid), 1);
        chk("mix_bytes", longint'(a_bytes), 40);
        chk("mix_frames", longint'(a_frames), 1);
        chk("mix_stall", longint'(a_stall), 5);
        chk("mix_idle", longint'(a_idle), 5);
        enable = 1'b0;
        step(0, 0, 0, 8'h00);
        step(0, 0, 0, 8'h00);

        // window_len changed mid-window, then enable dropped mid-window
        wl = 50;
        enable = 1'b1;
        step(1, 1, 0, 8'h01);
        for (int c = 1; c <= 50; c++) begin
            if (c == 11) wl = 30;
            step(1, 1, 0, 8'h01);
            if (c == 49) chk("len50_not_yet", longint'(a_valid), 0);
            if (c == 50) chk("len50_close", longint'(a_valid), 1);
        end
        chk("len50_bytes", longint'(a_bytes), 50);
        for (int c = 1; c <= 30; c++) begin
            step(1, 1, 0, 8'h01);
            if (c == 29) chk("len30_not_yet", longint'(a_valid), 0);
            if (c == 30) chk("len30_close", longint'(a_valid), 1);
        end
        chk("len30_bytes", longint'(a_bytes), 30);
        for (int c = 0; c < 20; c++) step(1, 1, 0, 8'hFF);
        enable = 1'b0;
        p0 = pulses;
        for (int c = 0; c < 40; c++) step(1, 1, 0, 8'hFF);
        chk("drop_no_pulse", longint'(pulses - p0), 0);
        chk("drop_bytes_kept", longint'(a_bytes), 30);

        // Reset mid-window, then a fresh window
        wl = 50;
        enable = 1'b1;
        step(1, 1, 0, 8'hFF);
        for (int c = 0; c < 40; c++) step(1, 1, 0, 8'hFF);
        p0 = pulses;
        rst_n = 1'b0;
        #1;
        chk("rst_bytes", longint'(a_bytes), 0);
        chk("rst_frames", longint'(a_frames), 0);
        chk("rst_valid", longint'(a_valid), 0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        step(1, 1, 0, 8'hFF);
        for (int c = 1; c <= 50; c++) begin
            step(1, 1, 0, 8'hFF);
            if (c == 49) chk("rst_no_pulse", longint'(pulses - p0), 0);
            if (c == 50) chk("rst_first_pub", longint'(a_valid), 1);
        end
        chk("rst_pub_bytes", longint'(a_bytes), 400);

        // Single-cycle windows
        enable = 1'b0;
        step(0, 0, 0, 8'h00);
        wl = 1;
        enable = 1'b1;
        step(1, 1, 0, 8'hFF);
        for (int c = 0; c < 10; c++) begin
            step(1, 1, 0, 8'hFF);
            chk("w1_valid", longint'(a_valid), 1);
            chk("w1_bytes", longint'(a_bytes), 8);
        end
        enable = 1'b0;
        repeat (3) step(0, 0, 0, 8'h00);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
